// File: rtl/hazard_scoreboard_ctrl_pkg.sv
// Shared types and constants for the decode-stage hazard controller.
package hazard_pkg;

    localparam int REG_CNT          = 32;
    localparam int REG_IDX_W        = 5;
    localparam int DEF_CNT_W        = 2;
    localparam int DEF_FLUSH_CYCLES = 2;
    localparam int FLUSH_CNT_W      = 3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } hz_state_t;

endpackage

// File: rtl/hazard_scoreboard_ctrl_scoreboard_bank.sv
// Per-register pending-write counters: 32 saturating up/down counters
// (x0 is never tracked), two source read ports, one destination read port
// and a sticky error flag for retires to a register with nothing pending.
module scoreboard_bank
    import hazard_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] rs1_idx,
    input  logic [REG_IDX_W-1:0] rs2_idx,
    input  logic [REG_IDX_W-1:0] rd_idx,
    output logic [CNT_W-1:0]     rs1_cnt,
    output logic [CNT_W-1:0]     rs2_cnt,
    output logic [CNT_W-1:0]     rd_cnt,
    input  logic                 inc_en,
    input  logic [REG_IDX_W-1:0] inc_idx,
    input  logic                 dec_en,
    input  logic [REG_IDX_W-1:0] dec_idx,
    output logic                 err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]   cnt [REG_CNT];
    logic [REG_CNT-1:0] inc_hit;
    logic [REG_CNT-1:0] dec_hit;

    // Entry 0 is cleared on reset and never written afterwards, so x0 reads 0.
    assign rs1_cnt = cnt[rs1_idx];
    assign rs2_cnt = cnt[rs2_idx];
    assign rd_cnt  = cnt[rd_idx];

    // One-hot select of the register being incremented / decremented this cycle.
    always_comb begin
        inc_hit = '0;
        dec_hit = '0;
        if (inc_en && inc_idx != '0) inc_hit[inc_idx] = 1'b1;
        if (dec_en && dec_idx != '0) dec_hit[dec_idx] = 1'b1;
    end

    // Counter update: inc and dec of the same register cancel; a retire at zero flags err.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_CNT; i++) cnt[i] <= '0;
            err <= 1'b0;
        end else begin
            for (int i = 1; i < REG_CNT; i++) begin
                if (inc_hit[i] && !dec_hit[i] && cnt[i] != CNT_MAX)
                    cnt[i] <= cnt[i] + 1'b1;
                else if (dec_hit[i] && !inc_hit[i] && cnt[i] != '0)
                    cnt[i] <= cnt[i] - 1'b1;
            end
            if (dec_en && dec_idx != '0 && cnt[dec_idx] == '0)
                err <= 1'b1;
        end
    end

endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// Decode-stage hazard controller: stalls IF/ID on RAW hazards against
// outstanding register writes and sequences front-end flushes after an EX
// redirect. Build option HAZARD_FORWARD_EN: with EX/MEM forwarding present,
// only load-use hazards stall (one cycle) and no scoreboard is built.
//
// Handshake: ID offers an instruction with id_valid; it is accepted (moves to
// EX) in exactly the cycles where issue=1. While id_valid=1 and issue=0 the
// instruction is either held (stall_id=1) or killed (redirect / flush), and
// a killed instruction never affects the scoreboard.
module hazard_scoreboard_ctrl
    import hazard_pkg::*;
#(
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic                 id_wr_en,
    input  logic                 id_is_load,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic                 wb_wr_en,
    input  logic                 ex_redirect,
    output logic                 stall_if,
    output logic                 stall_id,
    output logic                 bubble_ex,
    output logic                 flush_if_id,
    output logic                 issue,
    output logic                 sb_err,
    output hz_state_t            dbg_state
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);

    hz_state_t              state;
    logic [FLUSH_CNT_W-1:0] flush_cnt;
    logic                   hazard;
    logic                   in_flush;

`ifdef HAZARD_FORWARD_EN
    logic                 ld_valid;
    logic [REG_IDX_W-1:0] ld_rd;
    logic                 unused_wb;

    assign unused_wb = ^{wb_valid, wb_rd, wb_wr_en};
    assign sb_err    = 1'b0;

    // Load-use only: a source matching the load issued last cycle must wait one cycle.
    always_comb begin
        hazard = 1'b0;
        if (id_valid && ld_valid) begin
            if (id_use_rs1 && id_rs1 != '0 && id_rs1 == ld_rd) hazard = 1'b1;
            if (id_use_rs2 && id_rs2 != '0 && id_rs2 == ld_rd) hazard = 1'b1;
        end
    end

    // Remember the destination of a load issued this cycle; forget it one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_valid <= 1'b0;
            ld_rd    <= '0;
        end else if (issue && id_is_load && id_wr_en) begin
            ld_valid <= 1'b1;
            ld_rd    <= id_rd;
        end else begin
            ld_valid <= 1'b0;
            ld_rd    <= '0;
        end
    end
`else
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] rs1_cnt;
    logic [CNT_W-1:0] rs2_cnt;
    logic [CNT_W-1:0] rd_cnt;
    logic             unused_ld;

    assign unused_ld = id_is_load;

    scoreboard_bank #(
        .CNT_W (CNT_W)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .rs1_idx (id_rs1),
        .rs2_idx (id_rs2),
        .rd_idx  (id_rd),
        .rs1_cnt (rs1_cnt),
        .rs2_cnt (rs2_cnt),
        .rd_cnt  (rd_cnt),
        .inc_en  (issue && id_wr_en),
        .inc_idx (id_rd),
        .dec_en  (wb_valid && wb_wr_en),
        .dec_idx (wb_rd),
        .err     (sb_err)
    );

    // No forwarding: any pending write to a used source stalls, as does a saturated destination.
    always_comb begin
        hazard = 1'b0;
        if (id_valid) begin
            if (id_use_rs1 && id_rs1 != '0 && rs1_cnt != '0) hazard = 1'b1;
            if (id_use_rs2 && id_rs2 != '0 && rs2_cnt != '0) hazard = 1'b1;
            if (id_wr_en && id_rd != '0 && rd_cnt == CNT_MAX) hazard = 1'b1;
        end
    end
`endif

    assign in_flush    = (state == ST_FLUSH);
    assign issue       = id_valid & ~hazard & ~ex_redirect & ~in_flush;
    assign stall_id    = hazard & ~ex_redirect & ~in_flush;
    assign stall_if    = stall_id;
    assign bubble_ex   = stall_id | in_flush | ex_redirect;
    assign flush_if_id = in_flush;
    assign dbg_state   = state;

    // Control FSM: a redirect always wins and (re)starts the flush window.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RUN;
            flush_cnt <= '0;
        end else if (ex_redirect) begin
            state     <= ST_FLUSH;
            flush_cnt <= FLUSH_LOAD;
        end else begin
            case (state)
                ST_RUN: begin
                    if (hazard) state <= ST_STALL;
                end
                ST_STALL: begin
                    if (!hazard) state <= ST_RUN;
                end
                ST_FLUSH: begin
                    flush_cnt <= flush_cnt - 1'b1;
                    if (flush_cnt <= FLUSH_CNT_W'(1)) state <= ST_RUN;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Bench for hazard_scoreboard_ctrl: directed scenarios plus random traffic,
// checked every cycle against a reference model that tracks in-flight writes
// as a queue of destination registers and the flush window as cycles left.
module tb_hazard_scoreboard_ctrl;
    import hazard_pkg::*;

    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 2;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;
    localparam int EXP_W        = 7;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_use_rs1, id_use_rs2, id_wr_en, id_is_load;
    logic       wb_valid, wb_wr_en;
    logic [4:0] wb_rd;
    logic       ex_redirect;
    logic       stall_if, stall_id, bubble_ex, flush_if_id, issue, sb_err;
    logic [1:0] dbg_state;

    hazard_scoreboard_ctrl #(
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .id_rd       (id_rd),
        .id_wr_en    (id_wr_en),
        .id_is_load  (id_is_load),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_wr_en    (wb_wr_en),
        .ex_redirect (ex_redirect),
        .stall_if    (stall_if),
        .stall_id    (stall_id),
        .bubble_ex   (bubble_ex),
        .flush_if_id (flush_if_id),
        .issue       (issue),
        .sb_err      (sb_err),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [EXP_W-1:0] exp_q[$];
    int checks      = 0;
    int errors      = 0;
    int cycle_no    = 0;
    int stall_seen  = 0;
    int flush_seen  = 0;

    // ---------------- reference model ----------------
    logic [4:0] inflight_q[$];   // destinations issued but not yet retired, oldest first
    bit         m_err;
    int         flush_left;
    bit         ld_valid_m;
    logic [4:0] ld_rd_m;
    bit         last_issue;
    bit         last_killed;

    function automatic int pend(input logic [4:0] r);
        int n = 0;
        foreach (inflight_q[i]) if (inflight_q[i] == r) n++;
        return n;
    endfunction

    function automatic bit model_hazard();
        bit h = 1'b0;
`ifdef HAZARD_FORWARD_EN
        if (ld_valid_m) begin
            if (id_use_rs1 && id_rs1 != 0 && id_rs1 == ld_rd_m) h = 1'b1;
            if (id_use_rs2 && id_rs2 != 0 && id_rs2 == ld_rd_m) h = 1'b1;
        end
`else
        if (id_use_rs1 && id_rs1 != 0 && pend(id_rs1) != 0) h = 1'b1;
        if (id_use_rs2 && id_rs2 != 0 && pend(id_rs2) != 0) h = 1'b1;
        if (id_wr_en && id_rd != 0 && pend(id_rd) == CNT_MAX) h = 1'b1;
`endif
        return id_valid && h;
    endfunction

    task automatic retire(input logic [4:0] r);
        bit found = 1'b0;
        for (int i = 0; i < inflight_q.size(); i++) begin
            if (!found && inflight_q[i] == r) begin
                inflight_q.delete(i);
                found = 1'b1;
            end
        end
`ifndef HAZARD_FORWARD_EN
        if (!found) m_err = 1'b1;
`endif
    endtask

    task automatic model_reset();
        inflight_q.delete();
        m_err      = 1'b0;
        flush_left = 0;
        ld_valid_m = 1'b0;
        ld_rd_m    = '0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2,
                          input bit u2, input int rd, input bit wr, input bit ld);
        id_valid   = v;
        id_rs1     = 5'(rs1);
        id_use_rs1 = u1;
        id_rs2     = 5'(rs2);
        id_use_rs2 = u2;
        id_rd      = 5'(rd);
        id_wr_en   = wr;
        id_is_load = ld;
    endtask

    task automatic set_wb(input bit v, input int rd, input bit wr);
        wb_valid = v;
        wb_rd    = 5'(rd);
        wb_wr_en = wr;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        set_wb(0, 0, 0);
        ex_redirect = 1'b0;
    endtask

    // Predict this cycle's outputs, queue them, advance the model, move to next cycle.
    task automatic step();
        bit in_fl, haz, iss, stl, bub;
        in_fl = (flush_left > 0);
        haz   = model_hazard();
        iss   = id_valid && !haz && !ex_redirect && !in_fl;
        stl   = haz && !ex_redirect && !in_fl;
        bub   = stl || in_fl || ex_redirect;
        exp_q.push_back({in_fl, iss, stl, stl, bub, in_fl, m_err});
        last_issue  = iss;
        last_killed = ex_redirect || in_fl;
        if (wb_valid && wb_wr_en && wb_rd != 0) retire(wb_rd);
        if (iss && id_wr_en && id_rd != 0) inflight_q.push_back(id_rd);
        if (iss && id_is_load && id_wr_en) begin
            ld_valid_m = 1'b1;
            ld_rd_m    = id_rd;
        end else begin
            ld_valid_m = 1'b0;
            ld_rd_m    = '0;
        end
        if (ex_redirect) flush_left = FLUSH_CYCLES;
        else if (flush_left > 0) flush_left--;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [EXP_W-1:0] exp, act;
        forever begin
            @(negedge clk);
            cycle_no++;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                act = {(dbg_state == ST_FLUSH), issue, stall_if, stall_id,
                       bubble_ex, flush_if_id, sb_err};
                checks++;
                if (act !== exp) begin
                    errors++;
                    $display("FAIL outputs cycle=%0d got={fsm_flush,issue,stall_if,stall_id,bubble,flush,err}=%b expected=%b",
                             cycle_no, act, exp);
                end
                if (stall_id === 1'b1) stall_seen++;
                if (flush_if_id === 1'b1) flush_seen++;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int  s0, f0;
        bit  hold;
        model_reset();
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state with quiet inputs.
        step();
        step();

        // RAW on x5: stall until the cycle after its writeback.
        set_id(1, 0, 0, 0, 0, 5, 1, 0); step();
        s0 = stall_seen;
        set_id(1, 5, 1, 1, 1, 6, 1, 0); step(); step(); step();
        set_wb(1, 5, 1); step();
        set_wb(0, 0, 0); step();
`ifdef HAZARD_FORWARD_EN
        check_val("raw_x5_stall_cycles", stall_seen - s0, 0);
`else
        check_val("raw_x5_stall_cycles", stall_seen - s0, 4);
`endif
        idle(); set_wb(1, 6, 1); step();
        set_wb(0, 0, 0);

        // x0 is never tracked.
        set_id(1, 0, 0, 0, 0, 0, 1, 0); step();
        set_id(1, 0, 1, 0, 1, 3, 0, 0); step();
        idle(); step();

        // Redirect while stalled.
        set_id(1, 0, 0, 0, 0, 8, 1, 0); step();
        set_id(1, 8, 1, 0, 0, 9, 1, 0); step();
        f0 = flush_seen;
        ex_redirect = 1'b1; step();
        ex_redirect = 1'b0; step(); step();
        idle(); step(); step();
        check_val("flush_cycles", flush_seen - f0, FLUSH_CYCLES);
        set_wb(1, 8, 1); step();
        idle(); step();

        // Same-cycle inc/dec of x7, then saturation.
        set_id(1, 0, 0, 0, 0, 7, 1, 0); step();
        set_wb(1, 7, 1); step();
        set_wb(0, 0, 0); step(); step(); step(); step();
        idle();
        repeat (3) begin set_wb(1, 7, 1); step(); end
        idle(); step();

`ifdef HAZARD_FORWARD_EN
        // Load-use: exactly one stall; ALU-use: none.
        s0 = stall_seen;
        set_id(1, 0, 0, 0, 0, 3, 1, 1); step();
        set_id(1, 3, 1, 3, 1, 4, 1, 0); step(); step();
        check_val("load_use_stall_cycles", stall_seen - s0, 1);
        s0 = stall_seen;
        set_id(1, 0, 0, 0, 0, 3, 1, 0); step();
        set_id(1, 3, 1, 0, 0, 4, 1, 0); step();
        check_val("alu_use_stall_cycles", stall_seen - s0, 0);
        idle(); step();
`endif

        // Spurious retire of x9, then reset in the middle of a flush.
        do_reset(); step();
        set_wb(1, 9, 1); step();
        idle(); step(); step();
        ex_redirect = 1'b1; step();
        ex_redirect = 1'b0; step();
        do_reset();
        step(); step();

        // Random traffic; a stalled instruction is held in ID until it issues or is killed.
        hold = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!hold) begin
                id_valid   = ($urandom_range(0, 9) < 8);
                id_rs1     = 5'($urandom_range(0, 7));
                id_rs2     = 5'($urandom_range(0, 7));
                id_use_rs1 = 1'($urandom_range(0, 1));
                id_use_rs2 = 1'($urandom_range(0, 1));
                id_rd      = 5'($urandom_range(0, 7));
                id_wr_en   = ($urandom_range(0, 3) != 0);
                id_is_load = 1'($urandom_range(0, 1));
            end
            if (inflight_q.size() > 0 && $urandom_range(0, 9) < 4) begin
                set_wb(1, int'(inflight_q[0]), 1);
            end else begin
                set_wb(($urandom_range(0, 9) == 0), $urandom_range(0, 31), 0);
            end
            ex_redirect = ($urandom_range(0, 29) == 0);
            step();
            hold = id_valid && !last_issue && !last_killed;
        end

        idle(); step(); step();
        check_val("exp_q_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
